// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit blocks.
//   rx_state_t  : receiver FSM state encoding
//   parity_of() : parity bit for a data word (even, or odd when odd=1)
//   DEFAULT_*   : default frame geometry shared with the transmit side
package serial_pkg;

  localparam int MAX_DATA_BITS      = 9;
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Data narrower than MAX_DATA_BITS is zero-extended by the caller, which
  // leaves the XOR unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset_n : clock, async active-low reset (flushes the FIFO)
//   wr_en/wr_data: push; ignored when full unless a pop happens the same cycle
//   rd_en        : pop head; ignored when empty
//   rd_data      : head entry, 0 while empty
//   empty/full/count : occupancy (count is authoritative)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop frees the slot the push needs, so full+pop still accepts the push.
  assign do_push = wr_en && (!full || do_pop);

  // Storage is not reset; the empty gate below keeps stale words invisible.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// Oversampling serial receiver feeding a show-ahead receive FIFO.
//   clk, reset_n   : clock, async active-low reset
//   serial_in      : asynchronous serial line, idle high
//   rd_en          : pop FIFO head
//   rd_data        : FIFO head (show-ahead)
//   empty/full/count : FIFO occupancy
//   char_received  : one-cycle pulse when a character enters the FIFO
//   frame_err/parity_err/overrun : sticky error flags, cleared by err_clear
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int BAUD_DIV   = 27,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serial_in,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [CW-1:0]        count,
  output logic                 char_received,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clear
);

  localparam int TW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int OW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;

  rx_state_t            state;
  logic [1:0]           sync_q;
  logic                 rx;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [OW-1:0]        os_cnt;
  logic                 os_end;
  logic                 samp;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data;
  logic                 drop;

  // Two-flop synchroniser, preset to idle so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], serial_in};
  end
  assign rx = sync_q[1];

  // Sample-tick divider, re-phased on the falling edge that opens a frame.
  assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         tick_cnt <= '0;
    else if ((state == RX_IDLE) && !rx)   tick_cnt <= '0;
    else if (tick)                        tick_cnt <= '0;
    else                                  tick_cnt <= tick_cnt + 1'b1;
  end

  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign os_end = (state == RX_START) ? (os_cnt == OW'(HALF - 1))
                                      : (os_cnt == OW'(OVERSAMPLE - 1));
  assign samp   = tick && os_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      push_q     <= 1'b0;
      push_data  <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clear) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end

      if (state == RX_IDLE) os_cnt <= '0;
      else if (tick)        os_cnt <= os_end ? '0 : os_cnt + 1'b1;

      // Flag sets come after the clear so a same-cycle error wins.
      case (state)
        RX_IDLE: begin
          if (!rx) state <= RX_START;
        end
        RX_START: begin
          if (samp) begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
            state   <= rx ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (samp) begin
            if (DATA_BITS > 1) shreg <= {rx, shreg[DATA_BITS-1:1]};
            else               shreg <= DATA_BITS'(rx);
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= PARITY_EN ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (samp) begin
            par_bad <= (rx != parity_of(MAX_DATA_BITS'(shreg), PARITY_ODD));
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (samp) begin
            if (!rx) begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state <= RX_IDLE;
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                push_q    <= 1'b1;
                push_data <= shreg;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RX_WAIT_HIGH: begin
          // A held break parks here rather than re-arming on every tick.
          if (rx) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Full is judged on the push cycle so a concurrent pop still makes room.
  assign drop = push_q && full && !rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun       <= 1'b0;
      char_received <= 1'b0;
    end else begin
      char_received <= push_q && !drop;
      if (err_clear) overrun <= 1'b0;
      if (drop)      overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_q),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
